mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator/master for the 128-word x 32-bit data memory; drives address, write data and the W/R strobes, and consumes the memory's read data.
- Performs block copies of `len` words from a source region to a destination region on request from the control path (start/busy/done handshake).
- Sits between the control unit and the data memory; arbitration with the datapath happens outside this block.

Parameters:
- ADDR_W, 7, memory address width (128 locations).
- DATA_W, 32, memory word width.
- READ_LAT, 1, cycles from the memR cycle until memDataOut is valid (allowed range 1..4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous to clk, active-high.
- start  in  1  request a copy; sampled only in IDLE.
- srcAddr  in  ADDR_W  first source word address.
- dstAddr  in  ADDR_W  first destination word address.
- len  in  8  word count, 0..128; values >128 are clamped to 128.
- busy  out  1  high while a copy is in progress (READ/WAIT/WRITE).
- done  out  1  one-cycle pulse when a copy completes.
- wordsCopied  out  8  number of words written in the current or last copy.
- memAddress  out  ADDR_W  address to the memory.
- memDataIn  out  DATA_W  write data to the memory.
- memW  out  1  write strobe.
- memR  out  1  read strobe.
- memDataOut  in  DATA_W  read data from the memory.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. busy, done, memW and memR = 0. memAddress = 0, memDataIn = 0, wordsCopied = 0. Internal src/dst/len/index/data registers are cleared.
- Reset mid-copy: abort immediately with no further memW pulse and no done pulse. Words already written stay written.
- States: IDLE, READ, WAIT, WRITE, FIN.
- IDLE:
  - On start=1, latch srcAddr, dstAddr and clamped len.
  - Clear index i and wordsCopied.
  - If len==0, go to FIN; otherwise go to READ.
  - start while not in IDLE is ignored and is not queued.
- READ (1 cycle): memR=1, memAddress=src+i, memW=0. Go to WAIT.
- WAIT (READ_LAT cycles): memR=0, memW=0, memAddress held. On the final WAIT cycle's edge, latch memDataOut into the data register. Go to WRITE.
- WRITE (1 cycle): memW=1, memAddress=dst+i, memDataIn=latched data.
  - At the edge: i++ and wordsCopied++.
  - If i (after increment) == len, go to FIN; otherwise go to READ.
- FIN (1 cycle): done=1, busy=0, strobes 0. Go to IDLE.
- Strobes: memW and memR are never high in the same cycle. Each is high for exactly one cycle per word.
- Timing:
  - Each word costs 2+READ_LAT cycles.
  - busy is high for len*(2+READ_LAT) cycles, starting the cycle after start is accepted.
  - done is high in the cycle after the last WRITE.
  - For len==0, done is high in the cycle after start is accepted, with no memory strobes.
- Address arithmetic: src+i and dst+i are computed modulo 128, so regions wrap from 127 to 0.
- Overlap: the copy is always in ascending index order (forward). When dst is inside (src, src+len), earlier writes are re-read. This is the defined behaviour, not an error.
- memDataIn holds its last value when memW=0. wordsCopied holds its value after FIN until the next accepted start.
- Outputs are registered from the state and datapath registers; there is no combinational path from start to the mem* outputs.

Test Plan:
- Reset: rst=1 for 2 cycles while start=1 -> busy=0, done=0, memW=memR=0, memAddress=0, wordsCopied=0.
- Basic copy (READ_LAT=1): preload mem[10..13]={A,B,C,D}, start with src=10, dst=40, len=4 -> busy for 12 cycles; exactly 4 memR and 4 memW pulses; mem[40..43]={A,B,C,D}; done pulses once; wordsCopied=4.
- Zero length and clamp:
  - len=0 -> done in the cycle after start, no strobes.
  - len=200 -> exactly 128 memW pulses, wordsCopied=128.
- Wrap-around: src=126, dst=0, len=4 -> reads from addresses 126, 127, 0, 1; writes to 0..3; mem[0..3] = original {m126, m127, m0', m1'} where m0' and m1' are the already-overwritten values (forward-overlap semantics).
- Start while busy and back-to-back:
  - Pulse start with different args mid-copy -> ignored; the first copy completes unchanged.
  - start in the same cycle as FIN -> ignored.
  - start on the next IDLE cycle -> accepted.
- Reset mid-copy: assert rst during the third WAIT of a len=8 copy -> no further memW, no done pulse, mem[dst+0..dst+1] written, mem[dst+2..] untouched.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: memory-to-memory block copier for the 128 x 32 data memory.
// Copies `len` words (clamped to 128) from srcAddr to dstAddr in ascending order,
// one READ / WAIT(READ_LAT) / WRITE sequence per word, then pulses done.
// All outputs are registered; addresses wrap modulo 2**ADDR_W.
module mem_copy_engine #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [7:0]        len,
    output logic              busy,
    output logic              done,
    output logic [7:0]        wordsCopied,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memDataIn,
    output logic              memW,
    output logic              memR,
    input  logic [DATA_W-1:0] memDataOut
);

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAX_LEN = 128;
    localparam int unsigned WCNT_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   src_n;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   dst_n;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_n;
    logic [LEN_W-1:0]    idx_q;
    logic [LEN_W-1:0]    idx_n;
    logic [LEN_W-1:0]    idx_inc;
    logic [LEN_W-1:0]    len_clamped;
    logic [LEN_W-1:0]    cnt_n;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wcnt_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   data_n;
    logic                busy_n;
    logic                done_n;
    logic                memr_n;
    logic                memw_n;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_n     = state;
        src_n       = src_q;
        dst_n       = dst_q;
        len_n       = len_q;
        idx_n       = idx_q;
        cnt_n       = wordsCopied;
        wcnt_n      = wcnt_q;
        addr_n      = memAddress;
        data_n      = memDataIn;
        idx_inc     = idx_q + LEN_W'(1);
        len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

        case (state)
            S_IDLE: begin
                if (start) begin
                    src_n = srcAddr;
                    dst_n = dstAddr;
                    len_n = len_clamped;
                    idx_n = '0;
                    cnt_n = '0;
                    if (len_clamped == '0) begin
                        state_n = S_FIN;
                    end else begin
                        state_n = S_READ;
                        addr_n  = srcAddr;
                    end
                end
            end
            S_READ: begin
                state_n = S_WAIT;
                wcnt_n  = '0;
            end
            S_WAIT: begin
                // Read data is valid in the last wait cycle; capture it on that edge
                if (wcnt_q == WCNT_W'(READ_LAT - 1)) begin
                    state_n = S_WRITE;
                    data_n  = memDataOut;
                    addr_n  = dst_q + ADDR_W'(idx_q);
                end else begin
                    wcnt_n = wcnt_q + WCNT_W'(1);
                end
            end
            S_WRITE: begin
                idx_n = idx_inc;
                cnt_n = wordsCopied + LEN_W'(1);
                if (idx_inc == len_q) begin
                    state_n = S_FIN;
                end else begin
                    state_n = S_READ;
                    addr_n  = src_q + ADDR_W'(idx_inc);
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_READ) || (state_n == S_WAIT) || (state_n == S_WRITE);
        done_n = (state_n == S_FIN);
        memr_n = (state_n == S_READ);
        memw_n = (state_n == S_WRITE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            memR        <= 1'b0;
            memW        <= 1'b0;
            memAddress  <= '0;
            memDataIn   <= '0;
            wordsCopied <= '0;
        end else begin
            state       <= state_n;
            src_q       <= src_n;
            dst_q       <= dst_n;
            len_q       <= len_n;
            idx_q       <= idx_n;
            wcnt_q      <= wcnt_n;
            busy        <= busy_n;
            done        <= done_n;
            memR        <= memr_n;
            memW        <= memw_n;
            memAddress  <= addr_n;
            memDataIn   <= data_n;
            wordsCopied <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural memory, forward-copy
// reference model feeding read/write scoreboards, and per-copy timing checks.
module tb_mem_copy_engine;

    localparam int unsigned AW  = 7;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] srcAddr;
    logic [AW-1:0] dstAddr;
    logic [7:0]    len;
    logic          busy;
    logic          done;
    logic [7:0]    wordsCopied;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memDataIn;
    logic          memW;
    logic          memR;
    logic [DW-1:0] memDataOut;

    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_data;

    logic [DW-1:0] mem     [128];
    logic [DW-1:0] ref_mem [128];
    logic [DW-1:0] rd_pipe [LAT];

    logic [AW-1:0]    rq [$];
    logic [AW+DW-1:0] wq [$];

    int checks = 0;
    int errors = 0;
    int nbusy  = 0;
    int ndone  = 0;
    int nrd    = 0;
    int nwr    = 0;

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .srcAddr     (srcAddr),
        .dstAddr     (dstAddr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .wordsCopied (wordsCopied),
        .memAddress  (memAddress),
        .memDataIn   (memDataIn),
        .memW        (memW),
        .memR        (memR),
        .memDataOut  (memDataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Data memory with READ_LAT-cycle read pipeline
    always @(posedge clk) begin
        if (memW === 1'b1) mem[memAddress] <= memDataIn;
        else if (tb_we) mem[tb_addr] <= tb_data;
        if (memR === 1'b1) rd_pipe[0] <= mem[memAddress];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign memDataOut = rd_pipe[LAT-1];

    // Output monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (busy === 1'b1) nbusy++;
        if (done === 1'b1) ndone++;
        if (memR === 1'b1 || memW === 1'b1)
            check("strobe_excl", 64'(memR & memW), 64'd0);
        if (memR === 1'b1) begin
            nrd++;
            check("rd_expected", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
                ea = rq.pop_front();
                check("rd_addr", 64'(memAddress), 64'(ea));
            end
        end
        if (memW === 1'b1) begin
            nwr++;
            check("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                {ea, ed} = wq.pop_front();
                check("wr_addr", 64'(memAddress), 64'(ea));
                check("wr_data", 64'(memDataIn), 64'(ed));
            end
        end
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge in IDLE.
    // intr_at > 0 pulses a conflicting start in that cycle of the copy.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [7:0] l, input int intr_at, input string tag);
        int n;
        int t;
        bit seen;
        int b0, r0, w0, d0;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] v;
        n = (l > 8'd128) ? 128 : int'(l);
        for (int k = 0; k < n; k++) begin
            ra = AW'(int'(s) + k);
            wa = AW'(int'(d) + k);
            v  = ref_mem[ra];
            ref_mem[wa] = v;
            rq.push_back(ra);
            wq.push_back({wa, v});
        end
        b0 = nbusy; r0 = nrd; w0 = nwr; d0 = ndone;
        start   = 1'b1;
        srcAddr = s;
        dstAddr = d;
        len     = l;
        seen = 1'b0;
        t    = 0;
        while (!seen && t < n * (2 + LAT) + 8) begin
            @(negedge clk);
            t++;
            start = (t == intr_at);
            if (start) begin
                srcAddr = 7'd99;
                dstAddr = 7'd33;
                len     = 8'd5;
            end
            seen = (done === 1'b1);
        end
        check({tag, "_done_cycle"}, 64'(t), 64'(n * (2 + LAT) + 1));
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_cycles"}, 64'(nbusy - b0), 64'(n * (2 + LAT)));
        check({tag, "_memR_count"}, 64'(nrd - r0), 64'(n));
        check({tag, "_memW_count"}, 64'(nwr - w0), 64'(n));
        check({tag, "_done_count"}, 64'(ndone - d0), 64'd1);
        check({tag, "_wordsCopied"}, 64'(wordsCopied), 64'(n));
        check({tag, "_queues_empty"}, 64'(rq.size() + wq.size()), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] o126;
        logic [DW-1:0] o127;
        int d0, w0, nmis;

        rst     = 1'b1;
        start   = 1'b1;
        srcAddr = 7'd5;
        dstAddr = 7'd9;
        len     = 8'd3;
        tb_we   = 1'b0;
        tb_addr = '0;
        tb_data = '0;

        // Reset while start is held high
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_memW", 64'(memW), 64'd0);
        check("rst_memR", 64'(memR), 64'd0);
        check("rst_memAddress", 64'(memAddress), 64'd0);
        check("rst_wordsCopied", 64'(wordsCopied), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 128; k++) poke(AW'(k), 32'hC0DE_0000 | DW'(k * 7));
        poke(7'd10, 32'hAAAA_0001);
        poke(7'd11, 32'hBBBB_0002);
        poke(7'd12, 32'hCCCC_0003);
        poke(7'd13, 32'hDDDD_0004);

        run_copy(7'd10, 7'd40, 8'd4, 0, "basic");
        check("basic_m40", 64'(mem[40]), 64'h0000_0000_AAAA_0001);
        check("basic_m41", 64'(mem[41]), 64'h0000_0000_BBBB_0002);
        check("basic_m42", 64'(mem[42]), 64'h0000_0000_CCCC_0003);
        check("basic_m43", 64'(mem[43]), 64'h0000_0000_DDDD_0004);

        run_copy(7'd5, 7'd6, 8'd0, 0, "zero_len");
        run_copy(7'd3, 7'd64, 8'd200, 0, "clamp");

        o126 = mem[126];
        o127 = mem[127];
        run_copy(7'd126, 7'd0, 8'd4, 0, "wrap");
        check("wrap_m0", 64'(mem[0]), 64'(o126));
        check("wrap_m1", 64'(mem[1]), 64'(o127));
        check("wrap_m2", 64'(mem[2]), 64'(o126));
        check("wrap_m3", 64'(mem[3]), 64'(o127));

        run_copy(7'd20, 7'd50, 8'd3, 4, "start_mid");
        run_copy(7'd70, 7'd80, 8'd2, 7, "start_in_fin");
        run_copy(7'd30, 7'd100, 8'd2, 0, "back_to_back");

        // Reset during the third WAIT of an 8-word copy
        for (int k = 0; k < 3; k++) rq.push_back(AW'(60 + k));
        for (int k = 0; k < 2; k++) begin
            ref_mem[90 + k] = ref_mem[60 + k];
            wq.push_back({AW'(90 + k), ref_mem[60 + k]});
        end
        d0 = ndone;
        w0 = nwr;
        start   = 1'b1;
        srcAddr = 7'd60;
        dstAddr = 7'd90;
        len     = 8'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_in_wait", 64'({busy, memR, memW}), 64'b100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_wordsCopied", 64'(wordsCopied), 64'd0);
        check("abort_memAddress", 64'(memAddress), 64'd0);
        repeat (30) @(negedge clk);
        check("abort_no_done", 64'(ndone - d0), 64'd0);
        check("abort_memW_count", 64'(nwr - w0), 64'd2);
        check("abort_queues_empty", 64'(rq.size() + wq.size()), 64'd0);

        nmis = 0;
        for (int k = 0; k < 128; k++) if (mem[k] !== ref_mem[k]) nmis++;
        check("final_mem_image", 64'(nmis), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
